// File: rtl/lcd_capture.sv
// rtl/lcd_capture.sv - LCD pixel stream capture into a packed 2bpp framebuffer
module lcd_capture #(
   parameter int H_PIXELS = 160,
   parameter int V_LINES  = 144
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        lcd_pixel,
   input  logic [1:0]  lcd_color,
   input  logic        lcd_hsync,
   input  logic        lcd_vsync,
   output logic [12:0] fb_addr,
   output logic [7:0]  fb_data,
   output logic        fb_we,
   input  logic        fb_ready,
   output logic        frame_done,
   output logic        line_err,
   output logic        overflow,
   input  logic        err_clear
);

   localparam int XW = $clog2(H_PIXELS + 1);
   localparam int YW = $clog2(V_LINES + 3);
   localparam logic [12:0] LINE_BYTES = 13'(H_PIXELS / 4);

   typedef enum logic [1:0] {WAIT, ACTIVE, HBLANK, VBLANK} state_t;
   state_t state, state_nx;

   logic          hsync_q, vsync_q;
   logic          hs_rise, hs_fall, vs_rise, vs_fall;
   logic [XW-1:0] x, x_after;
   logic [YW-1:0] y;
   logic [12:0]   line_base;
   logic [5:0]    pack;
   logic          pix_take, pix_err, push, line_close, hs_err, frame_end, fr_err, start;
   logic [12:0]   push_addr;
   logic [7:0]    push_data;

   // two-entry write queue holding {addr, data}
   logic [20:0]   fifo_mem [2];
   logic          wr_ptr, rd_ptr;
   logic [1:0]    count;
   logic          pop, fifo_full, push_ok, drop;

   assign hs_rise = lcd_hsync & ~hsync_q;
   assign hs_fall = ~lcd_hsync & hsync_q;
   assign vs_rise = lcd_vsync & ~vsync_q;
   assign vs_fall = ~lcd_vsync & vsync_q;

   assign pix_take   = (state == ACTIVE) & lcd_pixel & (y < YW'(V_LINES)) & (x != XW'(H_PIXELS));
   assign pix_err    = (state == ACTIVE) & lcd_pixel & ~pix_take;
   assign push       = pix_take & (x[1:0] == 2'b11);
   assign push_addr  = line_base + 13'(x[XW-1:2]);
   assign push_data  = {pack, lcd_color};
   assign x_after    = x + XW'(pix_take);
   // vsync takes precedence: a simultaneous hsync edge does not close a line
   assign line_close = (state == ACTIVE) & hs_rise & ~vs_rise;
   assign hs_err     = line_close & (x_after != XW'(H_PIXELS));
   assign frame_end  = ((state == ACTIVE) | (state == HBLANK)) & vs_rise;
   assign fr_err     = frame_end & (y != YW'(V_LINES));
   assign start      = ((state == WAIT) | (state == VBLANK)) & vs_fall;

   assign fb_we     = (count != 2'd0);
   assign pop       = fb_we & fb_ready;
   assign fifo_full = (count == 2'd2);
   assign push_ok   = push & (~fifo_full | pop);
   assign drop      = push & fifo_full & ~pop;
   assign {fb_addr, fb_data} = fb_we ? fifo_mem[rd_ptr] : 21'd0;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= WAIT;
      else     state <= state_nx;
   end

   // next-state decode from sync edges
   always_comb begin
      state_nx = state;
      case (state)
         WAIT:    if (vs_fall) state_nx = ACTIVE;
         ACTIVE:  if (vs_rise) state_nx = VBLANK;
                  else if (hs_rise) state_nx = HBLANK;
         HBLANK:  if (vs_rise) state_nx = VBLANK;
                  else if (hs_fall) state_nx = ACTIVE;
         VBLANK:  if (vs_fall) state_nx = ACTIVE;
         default: state_nx = WAIT;
      endcase
   end

   // pixel counters, packing, sync history and sticky status
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hsync_q    <= 1'b0;
         vsync_q    <= 1'b0;
         x          <= '0;
         y          <= '0;
         line_base  <= '0;
         pack       <= '0;
         frame_done <= 1'b0;
         line_err   <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         hsync_q    <= lcd_hsync;
         vsync_q    <= lcd_vsync;
         frame_done <= frame_end;
         if (start) begin
            x         <= '0;
            y         <= '0;
            line_base <= '0;
            pack      <= '0;
         end else if (line_close) begin
            x         <= '0;
            if (y <= YW'(V_LINES)) y <= y + YW'(1);
            line_base <= line_base + LINE_BYTES;
            pack      <= '0;
         end else if (pix_take) begin
            x    <= x + XW'(1);
            pack <= push_data[5:0];
         end
         if (err_clear)                          line_err <= 1'b0;
         else if (pix_err | hs_err | fr_err)     line_err <= 1'b1;
         if (err_clear)                          overflow <= 1'b0;
         else if (drop)                          overflow <= 1'b1;
      end
   end

   // write queue; a push into a full queue succeeds only alongside a pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         count       <= 2'd0;
      end else begin
         if (push_ok) begin
            fifo_mem[wr_ptr] <= {push_addr, push_data};
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + 2'(push_ok) - 2'(pop);
      end
   end

endmodule

// File: tb/tb_lcd_capture.sv
// tb/tb_lcd_capture.sv - self-checking bench for lcd_capture
module tb_lcd_capture;

   localparam int H = 160;
   localparam int V = 144;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        lcd_pixel = 1'b0;
   logic [1:0]  lcd_color = 2'd0;
   logic        lcd_hsync = 1'b0;
   logic        lcd_vsync = 1'b0;
   logic [12:0] fb_addr;
   logic [7:0]  fb_data;
   logic        fb_we;
   logic        fb_ready = 1'b1;
   logic        frame_done;
   logic        line_err;
   logic        overflow;
   logic        err_clear = 1'b0;

   lcd_capture #(.H_PIXELS(H), .V_LINES(V)) dut (
      .clk(clk), .rst(rst), .lcd_pixel(lcd_pixel), .lcd_color(lcd_color),
      .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .fb_addr(fb_addr),
      .fb_data(fb_data), .fb_we(fb_we), .fb_ready(fb_ready),
      .frame_done(frame_done), .line_err(line_err), .overflow(overflow),
      .err_clear(err_clear)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   int          wr_count = 0;
   int          wc;
   logic [12:0] last_addr = '0;
   logic [7:0]  last_data = '0;
   logic [20:0] exp_q [$];

   // reference model: frame geometry and error bookkeeping in plain arithmetic
   int          mx, my;
   bit          m_active = 1'b0;
   logic [7:0]  mbyte;
   bit          exp_err = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // scoreboard: every accepted write must match the next expected byte
   always @(negedge clk) begin
      if (rst === 1'b0 && fb_we === 1'b1 && fb_ready === 1'b1) begin
         wr_count++;
         last_addr = fb_addr;
         last_data = fb_data;
         if (exp_q.size() == 0) begin
            check("expected_write_pending", 32'(exp_q.size()), 32'd1);
         end else begin
            logic [20:0] e;
            e = exp_q.pop_front();
            check("wr_addr", 32'(fb_addr), 32'(e[20:8]));
            check("wr_data", 32'(fb_data), 32'(e[7:0]));
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_pix(input logic [1:0] c, input bit keep);
      if (m_active) begin
         if (my >= V || mx >= H) exp_err = 1'b1;
         else begin
            mbyte = {mbyte[5:0], c};
            if (mx % 4 == 3 && keep) exp_q.push_back({13'(my * (H / 4) + mx / 4), mbyte});
            mx++;
         end
      end
   endtask

   task automatic model_hs;
      if (m_active) begin
         if (mx != H) exp_err = 1'b1;
         mx = 0;
         my++;
      end
   endtask

   task automatic pix(input logic [1:0] c, input bit keep);
      lcd_pixel = 1'b1;
      lcd_color = c;
      model_pix(c, keep);
      tick();
      lcd_pixel = 1'b0;
   endtask

   task automatic hsync_pulse(input bit with_pix);
      logic [1:0] c;
      c = 2'($urandom_range(0, 3));
      lcd_hsync = 1'b1;
      if (with_pix) begin
         lcd_pixel = 1'b1;
         lcd_color = c;
         model_pix(c, 1'b1);
      end
      model_hs();
      tick();
      lcd_pixel = 1'b0;
      tick();
      lcd_hsync = 1'b0;
      tick();
   endtask

   task automatic send_line(input int n);
      for (int i = 0; i < n; i++) pix(2'($urandom_range(0, 3)), 1'b1);
      hsync_pulse(1'b0);
   endtask

   task automatic vsync_start;
      lcd_vsync = 1'b1;
      tick();
      tick();
      lcd_vsync = 1'b0;
      tick();
      m_active = 1'b1;
      mx = 0;
      my = 0;
      mbyte = '0;
   endtask

   task automatic vsync_end;
      lcd_vsync = 1'b1;
      if (my != V) exp_err = 1'b1;
      m_active = 1'b0;
      tick();
      check("frame_done_pulse", 32'(frame_done), 32'd1);
      tick();
      check("frame_done_clear", 32'(frame_done), 32'd0);
   endtask

   task automatic clear_errs;
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      exp_err = 1'b0;
   endtask

   task automatic drain;
      for (int i = 0; i < 50 && fb_we; i++) tick();
      check("drain_done", 32'(fb_we), 32'd0);
   endtask

   initial begin
      // reset state
      tick();
      tick();
      check("rst_fb_we", 32'(fb_we), 32'd0);
      check("rst_fb_addr", 32'(fb_addr), 32'd0);
      check("rst_fb_data", 32'(fb_data), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_line_err", 32'(line_err), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      rst = 1'b0;
      tick();

      // pixels before the first vsync fall are ignored
      for (int i = 0; i < 8; i++) pix(2'($urandom_range(0, 3)), 1'b1);
      hsync_pulse(1'b1);
      tick();
      check("wait_no_writes", 32'(wr_count), 32'd0);
      check("wait_no_err", 32'(line_err), 32'd0);

      // single byte 3,2,1,0
      vsync_start();
      pix(2'd3, 1'b1);
      pix(2'd2, 1'b1);
      pix(2'd1, 1'b1);
      pix(2'd0, 1'b1);
      drain();
      check("first_count", 32'(wr_count), 32'd1);
      check("first_addr", 32'(last_addr), 32'd0);
      check("first_data", 32'(last_data), 32'hE4);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_active = 1'b0;
      exp_q.delete();
      tick();

      // full frame; first line closes with a pixel on the hsync edge cycle
      wr_count = 0;
      vsync_start();
      for (int l = 0; l < V; l++) begin
         if (l == 0) begin
            for (int i = 0; i < H - 1; i++) pix(2'($urandom_range(0, 3)), 1'b1);
            hsync_pulse(1'b1);
         end else begin
            send_line(H);
         end
      end
      check("frame_line_err_pre", 32'(line_err), 32'(exp_err));
      vsync_end();
      drain();
      check("frame_writes", 32'(wr_count), 32'd5760);
      check("frame_last_addr", 32'(last_addr), 32'd5759);
      check("frame_line_err", 32'(line_err), 32'd0);
      check("frame_overflow", 32'(overflow), 32'd0);

      // short line, then long line, then err_clear priority
      vsync_start();
      send_line(H - 3);
      check("short_line_err", 32'(line_err), 32'd1);
      send_line(4);
      drain();
      check("next_line_addr", 32'(last_addr), 32'd40);
      clear_errs();
      check("err_cleared", 32'(line_err), 32'd0);
      send_line(H + 1);
      drain();
      check("long_line_err", 32'(line_err), 32'(exp_err));
      clear_errs();
      for (int i = 0; i < 10; i++) pix(2'($urandom_range(0, 3)), 1'b1);
      lcd_hsync = 1'b1;
      err_clear = 1'b1;
      model_hs();
      exp_err = 1'b0;
      tick();
      err_clear = 1'b0;
      check("clear_priority", 32'(line_err), 32'd0);
      tick();
      lcd_hsync = 1'b0;
      tick();

      // sink stalled: two bytes held, third dropped
      vsync_end();
      clear_errs();
      vsync_start();
      fb_ready = 1'b0;
      for (int i = 0; i < 12; i++) begin
         pix(2'($urandom_range(0, 3)), i < 8);
         if (i >= 3) begin
            check("stall_we", 32'(fb_we), 32'd1);
            check("stall_addr", 32'(fb_addr), 32'd0);
         end
      end
      check("stall_overflow", 32'(overflow), 32'd1);
      wc = wr_count;
      fb_ready = 1'b1;
      drain();
      check("stall_drained", 32'(wr_count - wc), 32'd2);
      check("stall_last_addr", 32'(last_addr), 32'd1);
      clear_errs();
      check("overflow_cleared", 32'(overflow), 32'd0);

      // reset while a write is pending
      vsync_end();
      clear_errs();
      vsync_start();
      fb_ready = 1'b0;
      for (int i = 0; i < 4; i++) pix(2'($urandom_range(0, 3)), 1'b1);
      check("pending_we", 32'(fb_we), 32'd1);
      rst = 1'b1;
      #1;
      check("async_rst_we", 32'(fb_we), 32'd0);
      exp_q.delete();
      m_active = 1'b0;
      tick();
      rst = 1'b0;
      fb_ready = 1'b1;
      wc = wr_count;
      for (int i = 0; i < 8; i++) pix(2'($urandom_range(0, 3)), 1'b1);
      tick();
      check("post_rst_no_write", 32'(wr_count - wc), 32'd0);
      vsync_start();
      for (int i = 0; i < 4; i++) pix(2'($urandom_range(0, 3)), 1'b1);
      drain();
      check("post_rst_write", 32'(wr_count - wc), 32'd1);
      check("post_rst_addr", 32'(last_addr), 32'd0);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
